// File: rtl/regfile_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a register file.
// The master side is the environment (requesters plus register file);
// the slave side is the arbiter.
interface regfile_arbiter_if #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32
);
    localparam int AW = $clog2(SIZE);

    // Requester 0
    logic                req0_valid;
    logic                req0_ready;
    logic [AW-1:0]       req0_rs1;
    logic [AW-1:0]       req0_rs2;
    logic                req0_we;
    logic [AW-1:0]       req0_rd;
    logic [WORDSIZE-1:0] req0_wdata;
    logic                rsp0_valid;
    logic [WORDSIZE-1:0] rsp0_rs1_data;
    logic [WORDSIZE-1:0] rsp0_rs2_data;

    // Requester 1
    logic                req1_valid;
    logic                req1_ready;
    logic [AW-1:0]       req1_rs1;
    logic [AW-1:0]       req1_rs2;
    logic                req1_we;
    logic [AW-1:0]       req1_rd;
    logic [WORDSIZE-1:0] req1_wdata;
    logic                rsp1_valid;
    logic [WORDSIZE-1:0] rsp1_rs1_data;
    logic [WORDSIZE-1:0] rsp1_rs2_data;

    // Register file
    logic [AW-1:0]       rf_rs1;
    logic [AW-1:0]       rf_rs2;
    logic [WORDSIZE-1:0] rf_rs1_data;
    logic [WORDSIZE-1:0] rf_rs2_data;
    logic                rf_we;
    logic [AW-1:0]       rf_rd;
    logic [WORDSIZE-1:0] rf_wdata;

    modport master (
        output req0_valid, req0_rs1, req0_rs2, req0_we, req0_rd, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rs1_data, rsp0_rs2_data,
        output req1_valid, req1_rs1, req1_rs2, req1_we, req1_rd, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rs1_data, rsp1_rs2_data,
        input  rf_rs1, rf_rs2, rf_we, rf_rd, rf_wdata,
        output rf_rs1_data, rf_rs2_data
    );

    modport slave (
        input  req0_valid, req0_rs1, req0_rs2, req0_we, req0_rd, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rs1_data, rsp0_rs2_data,
        input  req1_valid, req1_rs1, req1_rs2, req1_we, req1_rd, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rs1_data, rsp1_rs2_data,
        output rf_rs1, rf_rs2, rf_we, rf_rd, rf_wdata,
        input  rf_rs1_data, rf_rs2_data
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a 2R1W register file.
// The granted requester drives the register file combinationally; read data
// is registered into that requester's response slot and flagged valid for
// the following cycle. Writes to x0 are dropped; no read/write forwarding.
module regfile_arbiter #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_arbiter_if.slave       bus,
    output logic                   last_grant
);
    localparam int AW = $clog2(SIZE);

    logic                grant0;
    logic                grant1;

    logic                last_grant_q,  last_grant_d;
    logic                rsp0_valid_q,  rsp0_valid_d;
    logic                rsp1_valid_q,  rsp1_valid_d;
    logic [WORDSIZE-1:0] rsp0_rs1_q,    rsp0_rs1_d;
    logic [WORDSIZE-1:0] rsp0_rs2_q,    rsp0_rs2_d;
    logic [WORDSIZE-1:0] rsp1_rs1_q,    rsp1_rs1_d;
    logic [WORDSIZE-1:0] rsp1_rs2_q,    rsp1_rs2_d;

    // Round-robin grant: a lone requester wins, contention goes to the
    // requester that was not granted last; nothing is granted in reset.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // Steer the granted access onto the register file and compute next state.
    always_comb begin
        bus.rf_rs1    = '0;
        bus.rf_rs2    = '0;
        bus.rf_we     = 1'b0;
        bus.rf_rd     = '0;
        bus.rf_wdata  = '0;
        last_grant_d  = last_grant_q;
        rsp0_valid_d  = grant0;
        rsp1_valid_d  = grant1;
        rsp0_rs1_d    = rsp0_rs1_q;
        rsp0_rs2_d    = rsp0_rs2_q;
        rsp1_rs1_d    = rsp1_rs1_q;
        rsp1_rs2_d    = rsp1_rs2_q;

        if (grant0) begin
            bus.rf_rs1   = bus.req0_rs1;
            bus.rf_rs2   = bus.req0_rs2;
            bus.rf_we    = bus.req0_we && (bus.req0_rd != '0);
            bus.rf_rd    = bus.req0_rd;
            bus.rf_wdata = bus.req0_wdata;
            last_grant_d = 1'b0;
            rsp0_rs1_d   = bus.rf_rs1_data;
            rsp0_rs2_d   = bus.rf_rs2_data;
        end else if (grant1) begin
            bus.rf_rs1   = bus.req1_rs1;
            bus.rf_rs2   = bus.req1_rs2;
            bus.rf_we    = bus.req1_we && (bus.req1_rd != '0);
            bus.rf_rd    = bus.req1_rd;
            bus.rf_wdata = bus.req1_wdata;
            last_grant_d = 1'b1;
            rsp1_rs1_d   = bus.rf_rs1_data;
            rsp1_rs2_d   = bus.rf_rs2_data;
        end
    end

    // State register with synchronous reset; last_grant resets to 1 so
    // requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            last_grant_q <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            // NOTE: the response data registers are reset too because their
            // contents are visible on the ports before the first response.
            rsp0_rs1_q   <= '0;
            rsp0_rs2_q   <= '0;
            rsp1_rs1_q   <= '0;
            rsp1_rs2_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rs1_q   <= rsp0_rs1_d;
            rsp0_rs2_q   <= rsp0_rs2_d;
            rsp1_rs1_q   <= rsp1_rs1_d;
            rsp1_rs2_q   <= rsp1_rs2_d;
        end
    end

    // Response valid is masked by reset so a reset in the cycle after a grant
    // swallows the pending pulse.
    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.rsp0_valid    = rsp0_valid_q && !reset;
    assign bus.rsp1_valid    = rsp1_valid_q && !reset;
    assign bus.rsp0_rs1_data = rsp0_rs1_q;
    assign bus.rsp0_rs2_data = rsp0_rs2_q;
    assign bus.rsp1_rs1_data = rsp1_rs1_q;
    assign bus.rsp1_rs2_data = rsp1_rs2_q;
    assign last_grant        = last_grant_q;
endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter WORDSIZE, default 64, giving the register data width in bits.
REQ-002 The block SHALL have parameter SIZE, default 32, giving the register count; register address width is 5 bits.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows; N = 0,1 denotes one port per requester:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
reqN_valid  in  1  requester N presents an access
reqN_ready  out  1  combinational grant to requester N this cycle
reqN_rs1  in  5  first read address
reqN_rs2  in  5  second read address
reqN_we  in  1  access includes a write
reqN_rd  in  5  write address
reqN_wdata  in  WORDSIZE  write data
rspN_valid  out  1  one-cycle pulse, read data for requester N valid
rspN_rs1_data  out  WORDSIZE  registered rs1 read data
rspN_rs2_data  out  WORDSIZE  registered rs2 read data
rf_rs1  out  5  register-file read address 1
rf_rs2  out  5  register-file read address 2
rf_rs1_data  in  WORDSIZE  register-file read data 1, combinational
rf_rs2_data  in  WORDSIZE  register-file read data 2, combinational
rf_we  out  1  register-file write enable
rf_rd  out  5  register-file write address
rf_wdata  out  WORDSIZE  register-file write data
last_grant  out  1  index of the most recently granted requester

Function
REQ-005 Grant: at most one reqN_ready SHALL be high per cycle, and only when reqN_valid is high.
REQ-006 Single request: a lone valid requester SHALL be granted in the same cycle.
REQ-007 Round-robin: when both requesters are valid, the block SHALL grant the requester other than last_grant.
REQ-008 Update: on each grant, last_grant SHALL take the granted index at the clock edge; it SHALL hold when there is no grant.
REQ-009 Transfer: an access transfers when reqN_valid and reqN_ready are both high; requesters hold their inputs stable until that happens.
REQ-010 Read path: in the grant cycle, rf_rs1 and rf_rs2 SHALL equal the granted requester's rs1 and rs2.
REQ-011 Read path, idle: with no grant, rf_rs1 and rf_rs2 SHALL be 0.
REQ-012 Read capture: at the grant-cycle clock edge, rf_rs1_data and rf_rs2_data SHALL be captured into the granted requester's rsp registers.
REQ-013 Read latency: rspN_valid SHALL pulse high for exactly the one cycle after the grant.
REQ-014 Response hold: rspN data SHALL hold its last value until that requester's next response.
REQ-015 Write path: in the grant cycle, rf_we SHALL equal the granted requester's we AND (rd != 0), so writes to x0 are suppressed.
REQ-016 Write path: in the grant cycle, rf_rd and rf_wdata SHALL equal the granted requester's rd and wdata.
REQ-017 Write path, idle: with no grant, rf_we, rf_rd and rf_wdata SHALL be 0.
REQ-018 No forwarding: a read and write to the same register in the same access SHALL return the pre-write value; no forwarding is performed.
REQ-019 Back-to-back: grants SHALL be possible every cycle; sustained dual requests alternate 0,1,0,1.
REQ-020 Requests SHALL NOT be queued; a denied requester re-presents its access in the next cycle.

Reset
REQ-021 While reset is high, reqN_ready, rspN_valid and rf_we SHALL be 0, and no grant or capture SHALL occur.
REQ-022 At reset, last_grant SHALL be 1, so requester 0 wins the first contention.
REQ-023 At reset, rspN_rs1_data and rspN_rs2_data SHALL be 0.
REQ-024 Reset asserted in the cycle after a grant SHALL suppress that cycle's rspN_valid; the write already committed is not undone.

Verification
REQ-025 After reset, req0 only: rs1=4, rs2=5, rf model x4=0xAA, x5=0xBB -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_rs1_data=0xAA, rsp0_rs2_data=0xBB.
REQ-026 Both valid for 4 cycles after reset -> grants 0,1,0,1; last_grant=1 at end; each rspN_valid pulses twice.
REQ-027 req1: we=1, rd=0, wdata=0xFF -> rf_we=0; a subsequent read of x0 returns 0.
REQ-028 req0: we=1, rd=7, wdata=0x1234, rs1=7, with x7=0x99 before -> rsp0_rs1_data=0x99; a later read of x7 returns 0x1234.
REQ-029 Reset asserted in the cycle after a grant -> rsp0_valid=0, last_grant=1, all rsp data 0.
